me_frame_scheduler: RTL and testbench
=====================================

Name: me_frame_scheduler

Overview:
Sequences the 16-PE full-search motion-estimation engine across every macroblock of a frame, in raster order. For each macroblock it:
- requests a load of the reference block and search window;
- holds the engine's start level until the engine reports completion;
- captures the best distortion and motion vector into an output result FIFO.
It sits between the frame-level host/DMA and the motion-estimation top level. It also provides a watchdog and drops start between jobs so the engine's search counter re-initialises.

Parameters:
MB_COLS, 4, macroblocks per row (1..255)
MB_ROWS, 3, macroblock rows per frame (1..255)
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
TIMEOUT, 5000, max cycles in RUN before a job is abandoned (must exceed 4111)

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high; all state cleared
frame_start  input  1  one-cycle pulse; begins a frame when idle
busy  output  1  high from accepted frame_start until the cycle after frame_done
frame_done  output  1  one-cycle pulse when the last macroblock's result is pushed
load_req  output  1  request the memory loader to fill R/S memories for (load_mb_x, load_mb_y)
load_ack  input  1  loader done; sampled only while load_req=1
load_mb_x  output  8  column of macroblock being loaded/processed
load_mb_y  output  8  row of macroblock being loaded/processed
me_start  output  1  engine start level
me_completed  input  1  engine completion flag
me_best_distance  input  8  engine best distortion
me_motion_x  input  4  engine best vector X
me_motion_y  input  4  engine best vector Y
res_valid  output  1  FIFO head valid
res_ready  input  1  consumer accepts head when res_valid=1
res_mb_x  output  8  head: macroblock column
res_mb_y  output  8  head: macroblock row
res_distance  output  8  head: best distortion (8'hFF on timeout)
res_mvx  output  4  head: motion X (0 on timeout)
res_mvy  output  4  head: motion Y (0 on timeout)
res_timeout  output  1  head: job abandoned by watchdog
timeout_sticky  output  1  set on any timeout; cleared only by reset or accepted frame_start

Behaviour:
- Reset values: state=IDLE; all outputs 0; mb counters 0; FIFO empty; watchdog 0.
- FSM states: IDLE, LOAD, RUN, CAPTURE, RELEASE.
- IDLE:
  - frame_start=1: clear mb_x/mb_y, clear timeout_sticky, set busy, go to LOAD next cycle.
  - frame_start in any other state is ignored.
- LOAD:
  - load_req=1, load_mb_x/y driven from the counters.
  - On load_ack=1: load_req drops next cycle; go to RUN.
  - No timeout in LOAD.
- RUN:
  - me_start=1; watchdog increments each cycle starting from 0.
  - me_completed=1 (engine asserts it 4111 cycles after start rises): go to CAPTURE.
  - Watchdog reaches TIMEOUT-1 with no completion: go to CAPTURE with the timeout flag set.
- CAPTURE:
  - me_start held at 1 so the engine outputs remain frozen.
  - If FIFO not full: push {mb_x, mb_y, distance, mvx, mvy, timeout}, then go to RELEASE.
  - Timeout entries push distance=8'hFF, mvx=mvy=0, res_timeout=1, and set timeout_sticky.
  - If FIFO full: stall in CAPTURE; the watchdog is not incremented.
- RELEASE:
  - me_start=0 for exactly one cycle (engine counter clears); watchdog clears.
  - If this was the last macroblock (mb_x=MB_COLS-1 and mb_y=MB_ROWS-1): frame_done pulses on the push cycle; go to IDLE; busy drops on entry to IDLE.
  - Otherwise advance raster: mb_x+1, wrapping to 0 with mb_y+1; go to LOAD.
- FIFO behaviour:
  - Pop when res_valid && res_ready.
  - Push allowed only when not full, judged on the pre-pop count.
  - Simultaneous push and pop: both occur, occupancy unchanged.
  - Head outputs are registered, stable while res_valid && !res_ready; they hold their last value (not required) when empty.
- me_start is never high in IDLE, LOAD or RELEASE. The minimum low gap between jobs is therefore >=2 cycles (RELEASE + LOAD).
- Asynchronous reset mid-frame: immediate return to IDLE; me_start and load_req drop; FIFO contents discarded; no frame_done.
- MB_COLS=MB_ROWS=1: one job, then frame_done.

Test Plan:
- Reset, then frame_start with MB_COLS=2, MB_ROWS=2, loader acks after 3 cycles, engine model completes after 4111 cycles with dist=0x23 -> 4 FIFO entries in order (0,0),(1,0),(0,1),(1,1); exactly one frame_done pulse; busy low afterwards.
- Between consecutive jobs -> me_start low for >=2 cycles; load_req never overlaps me_start.
- res_ready held 0 with FIFO_DEPTH=4 and 6 macroblocks -> scheduler stalls in CAPTURE after 4 entries with me_start=1; releasing ready drains all entries in order; no entry lost or duplicated.
- Engine never completes, TIMEOUT=5000 -> entry with res_distance=0xFF, mvx=mvy=0, res_timeout=1; timeout_sticky=1; next macroblock still processed.
- Assert reset during RUN of the 2nd macroblock -> me_start, load_req, res_valid, busy all 0 immediately; a new frame_start restarts at (0,0).
- frame_start pulsed while busy -> ignored: mb sequence and frame_done count unchanged.

Source files
------------

// File: rtl/me_frame_scheduler_if.sv
// rtl/me_frame_scheduler_if.sv - host, loader, engine and result-FIFO signals of the frame scheduler
interface me_frame_scheduler_if;
    logic       frame_start;
    logic       busy;
    logic       frame_done;
    logic       load_req;
    logic       load_ack;
    logic [7:0] load_mb_x;
    logic [7:0] load_mb_y;
    logic       me_start;
    logic       me_completed;
    logic [7:0] me_best_distance;
    logic [3:0] me_motion_x;
    logic [3:0] me_motion_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_mb_x;
    logic [7:0] res_mb_y;
    logic [7:0] res_distance;
    logic [3:0] res_mvx;
    logic [3:0] res_mvy;
    logic       res_timeout;
    logic       timeout_sticky;

    // Scheduler side
    modport master (
        input  frame_start, load_ack, me_completed, me_best_distance,
               me_motion_x, me_motion_y, res_ready,
        output busy, frame_done, load_req, load_mb_x, load_mb_y, me_start,
               res_valid, res_mb_x, res_mb_y, res_distance, res_mvx, res_mvy,
               res_timeout, timeout_sticky
    );

    // Host / loader / engine / consumer side
    modport slave (
        output frame_start, load_ack, me_completed, me_best_distance,
               me_motion_x, me_motion_y, res_ready,
        input  busy, frame_done, load_req, load_mb_x, load_mb_y, me_start,
               res_valid, res_mb_x, res_mb_y, res_distance, res_mvx, res_mvy,
               res_timeout, timeout_sticky
    );
endinterface

// File: rtl/me_frame_scheduler.sv
// rtl/me_frame_scheduler.sv - raster-order macroblock sequencer for the motion-estimation engine
module me_frame_scheduler #(
    parameter int MB_COLS    = 4,
    parameter int MB_ROWS    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 5000
) (
    input  logic               clock,
    input  logic               reset,
    me_frame_scheduler_if.master bus
);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPTURE, S_RELEASE} state_t;

    typedef struct packed {
        logic [7:0] mb_x;
        logic [7:0] mb_y;
        logic [7:0] distance;
        logic [3:0] mvx;
        logic [3:0] mvy;
        logic       timeout;
    } entry_t;

    state_t            r_state;
    logic [7:0]        r_mb_x;
    logic [7:0]        r_mb_y;
    logic [WD_W-1:0]   r_wdog;
    logic              r_timeout_flag;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_load_req;
    logic              r_me_start;
    logic              r_sticky;

    entry_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_last;
    entry_t            w_entry;
    entry_t            w_head;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_valid = (r_count != '0);
    // Fullness is judged on the pre-pop count, so a full FIFO never accepts even when draining.
    assign w_push  = (r_state == S_CAPTURE) && !w_full;
    assign w_pop   = w_valid && bus.res_ready;
    assign w_last  = (r_mb_x == 8'(MB_COLS - 1)) && (r_mb_y == 8'(MB_ROWS - 1));

    // Abandoned jobs report worst-case distortion and a null vector.
    always_comb begin
        w_entry.mb_x     = r_mb_x;
        w_entry.mb_y     = r_mb_y;
        w_entry.distance = r_timeout_flag ? 8'hFF : bus.me_best_distance;
        w_entry.mvx      = r_timeout_flag ? 4'h0  : bus.me_motion_x;
        w_entry.mvy      = r_timeout_flag ? 4'h0  : bus.me_motion_y;
        w_entry.timeout  = r_timeout_flag;
    end

    // Job sequencer: load, run the engine, capture, then drop start for one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_mb_x         <= '0;
            r_mb_y         <= '0;
            r_wdog         <= '0;
            r_timeout_flag <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_load_req     <= 1'b0;
            r_me_start     <= 1'b0;
            r_sticky       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        r_mb_x     <= '0;
                        r_mb_y     <= '0;
                        r_sticky   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_load_req <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.load_ack) begin
                        r_load_req <= 1'b0;
                        r_me_start <= 1'b1;
                        r_wdog     <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.me_completed) begin
                        r_timeout_flag <= 1'b0;
                        r_state        <= S_CAPTURE;
                    end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                        r_timeout_flag <= 1'b1;
                        r_state        <= S_CAPTURE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Start stays high while stalled so the engine result stays frozen.
                    if (!w_full) begin
                        r_me_start <= 1'b0;
                        if (r_timeout_flag) r_sticky <= 1'b1;
                        if (w_last) r_frame_done <= 1'b1;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_wdog <= '0;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_mb_x == 8'(MB_COLS - 1)) begin
                            r_mb_x <= '0;
                            r_mb_y <= r_mb_y + 8'd1;
                        end else begin
                            r_mb_x <= r_mb_x + 8'd1;
                        end
                        r_load_req <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result FIFO storage and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign w_head             = r_mem[r_rd_ptr];
    assign bus.busy           = r_busy;
    assign bus.frame_done     = r_frame_done;
    assign bus.load_req       = r_load_req;
    assign bus.load_mb_x      = r_mb_x;
    assign bus.load_mb_y      = r_mb_y;
    assign bus.me_start       = r_me_start;
    assign bus.timeout_sticky = r_sticky;
    assign bus.res_valid      = w_valid;
    assign bus.res_mb_x       = w_head.mb_x;
    assign bus.res_mb_y       = w_head.mb_y;
    assign bus.res_distance   = w_head.distance;
    assign bus.res_mvx        = w_head.mvx;
    assign bus.res_mvy        = w_head.mvy;
    assign bus.res_timeout    = w_head.timeout;
endmodule

// File: tb/tb_me_frame_scheduler.sv
// tb/tb_me_frame_scheduler.sv - scoreboard bench for me_frame_scheduler
module tb_me_frame_scheduler;
    localparam int MB_COLS    = 3;
    localparam int MB_ROWS    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 5000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    me_frame_scheduler_if bus();

    me_frame_scheduler #(
        .MB_COLS(MB_COLS), .MB_ROWS(MB_ROWS), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int vectors = 0;
    int errors  = 0;
    int fd_cnt  = 0;
    int eng_lat = 4111;
    bit hang_en = 1'b0;
    int hang_x  = 0;
    int hang_y  = 0;
    logic [32:0] exp_q [$];

    function automatic logic [32:0] exp_entry(int x, int y, bit to);
        int idx;
        idx = y * MB_COLS + x;
        if (to) return {8'(x), 8'(y), 8'hFF, 4'h0, 4'h0, 1'b1};
        return {8'(x), 8'(y), 8'(8'h23 + 8'(idx)), 4'(x + 1), 4'(y + 2), 1'b0};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Loader model: acknowledges three cycles after a request appears.
    int ld_cnt = 0;
    always @(negedge clock) begin
        if (bus.load_req && !bus.load_ack) begin
            ld_cnt++;
            if (ld_cnt == 3) bus.load_ack = 1'b1;
        end else begin
            bus.load_ack = 1'b0;
            ld_cnt = 0;
        end
    end

    // Engine model: completes eng_lat cycles after start rises unless this job is set to hang.
    int eng_cnt = 0;
    int eng_x = 0;
    int eng_y = 0;
    always @(negedge clock) begin
        if (!bus.me_start) begin
            eng_cnt = 0;
            bus.me_completed = 1'b0;
        end else begin
            if (eng_cnt == 0) begin
                eng_x = int'(bus.load_mb_x);
                eng_y = int'(bus.load_mb_y);
            end
            eng_cnt++;
            if (eng_cnt >= eng_lat && !(hang_en && eng_x == hang_x && eng_y == hang_y)) begin
                bus.me_completed     = 1'b1;
                bus.me_best_distance = 8'(8'h23 + 8'(eng_y * MB_COLS + eng_x));
                bus.me_motion_x      = 4'(eng_x + 1);
                bus.me_motion_y      = 4'(eng_y + 2);
            end
        end
    end

    // Result monitor: compares every accepted head against the scoreboard.
    always @(negedge clock) begin
        logic [32:0] got;
        logic [32:0] want;
        if (!reset && bus.res_valid && bus.res_ready) begin
            got = {bus.res_mb_x, bus.res_mb_y, bus.res_distance, bus.res_mvx, bus.res_mvy, bus.res_timeout};
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got %0h expected none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL result_entry: got %0h expected %0h", got, want);
                end
            end
        end
    end

    // Protocol monitor: start gap between jobs and load/start exclusivity.
    int  low_run    = 100;
    bit  prev_start = 1'b0;
    bit  prev_lreq  = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            low_run = 100;
        end else begin
            if (bus.frame_done) fd_cnt++;
            if (bus.me_start) begin
                if (!prev_start) begin
                    vectors++;
                    if (low_run < 2) begin
                        errors++;
                        $display("FAIL start_gap: got %0d expected >=2", low_run);
                    end
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            if (bus.load_req && !prev_lreq) begin
                vectors++;
                if (bus.me_start) begin
                    errors++;
                    $display("FAIL load_start_overlap: got me_start=1 expected 0");
                end
            end
        end
        prev_start = bus.me_start;
        prev_lreq  = bus.load_req;
    end

    task automatic push_frame();
        for (int y = 0; y < MB_ROWS; y++)
            for (int x = 0; x < MB_COLS; x++)
                exp_q.push_back(exp_entry(x, y, hang_en && x == hang_x && y == hang_y));
    endtask

    task automatic pulse_start();
        @(negedge clock) bus.frame_start = 1'b1;
        @(negedge clock) bus.frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(int limit, int fd_before);
        int n = 0;
        while (!bus.frame_done && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("frame_done_seen", 64'(bus.frame_done), 64'd1);
        @(negedge clock);
        check("busy_after_done", 64'(bus.busy), 64'd0);
        repeat (4) @(negedge clock);
        check("frame_done_count", 64'(fd_cnt - fd_before), 64'd1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int fd0;
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.res_ready = 1'b1;
        bus.load_ack = 1'b0;
        bus.me_completed = 1'b0;
        bus.me_best_distance = 8'h0;
        bus.me_motion_x = 4'h0;
        bus.me_motion_y = 4'h0;
        repeat (3) @(negedge clock);
        check("reset_outputs",
              64'({bus.busy, bus.frame_done, bus.load_req, bus.me_start, bus.res_valid, bus.timeout_sticky}),
              64'd0);
        check("reset_mb", 64'({bus.load_mb_x, bus.load_mb_y}), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Frame 1: full engine latency, extra frame_start while busy must be ignored.
        eng_lat = 4111;
        fd0 = fd_cnt;
        push_frame();
        pulse_start();
        check("busy_after_start", 64'(bus.busy), 64'd1);
        n = 0;
        while (!(bus.load_mb_x == 8'd1 && bus.me_start) && n < 6000) begin
            @(negedge clock);
            n++;
        end
        check("second_job_reached", 64'(bus.load_mb_x), 64'd1);
        pulse_start();
        wait_frame_done(6 * 4200, fd0);
        check("sticky_clean_frame", 64'(bus.timeout_sticky), 64'd0);

        // Frame 2: consumer stalled, scheduler must park in capture after four entries.
        eng_lat = 30;
        bus.res_ready = 1'b0;
        fd0 = fd_cnt;
        push_frame();
        pulse_start();
        repeat (400) @(negedge clock);
        check("stall_me_start", 64'(bus.me_start), 64'd1);
        check("stall_mb", 64'({bus.load_mb_x, bus.load_mb_y}), 64'h0101);
        check("stall_valid_busy", 64'({bus.res_valid, bus.busy, bus.load_req}), 64'b110);
        check("stall_no_done", 64'(fd_cnt - fd0), 64'd0);
        bus.res_ready = 1'b1;
        wait_frame_done(1000, fd0);

        // Frame 3: job (1,0) never completes and is abandoned by the watchdog.
        hang_en = 1'b1;
        hang_x = 1;
        hang_y = 0;
        fd0 = fd_cnt;
        push_frame();
        pulse_start();
        wait_frame_done(TIMEOUT + 1000, fd0);
        check("sticky_after_timeout", 64'(bus.timeout_sticky), 64'd1);
        hang_en = 1'b0;

        // Frame 4: reset while the second job runs, then a clean restart.
        exp_q.push_back(exp_entry(0, 0, 1'b0));
        pulse_start();
        n = 0;
        while (!(bus.load_mb_x == 8'd1 && bus.me_start) && n < 500) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        check("pre_reset_in_run", 64'({bus.me_start, bus.load_mb_x}), 64'h101);
        fd0 = fd_cnt;
        reset = 1'b1;
        #1;
        check("mid_reset_outputs",
              64'({bus.me_start, bus.load_req, bus.res_valid, bus.busy, bus.frame_done, bus.timeout_sticky}),
              64'd0);
        check("mid_reset_scoreboard", 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("no_done_on_reset", 64'(fd_cnt - fd0), 64'd0);
        push_frame();
        pulse_start();
        n = 0;
        while (!bus.load_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("restart_mb", 64'({bus.load_req, bus.load_mb_x, bus.load_mb_y}), 64'h10000);
        wait_frame_done(1000, fd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
